muldiv_unit: RTL

Parametrised iterative multiply/divide unit that holds its results in HI/LO registers. It serves as the multi-cycle arithmetic companion to the single-cycle ALU datapath. It supports signed and unsigned multiply and divide, with a start/busy/done handshake so the controller no longer relies on a fixed wait time. Results are read back through MFHI/MFLO using the same function-code convention as the ALU.

---
 rtl/muldiv_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide into HI/LO, one operand bit per cycle.
// Result and done arrive WIDTH+1 cycles after an accepted start; starts while busy are dropped.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] Output,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     addend_q, hi_q, lo_q;
  logic [CW-1:0]        cnt_q;
  logic                 is_div_q, neg_q, rneg_q, bz_q;
  logic                 busy_q, done_q, dz_q;

  logic                 is_op, sgn_op;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH:0]     div_shift;
  logic [2*WIDTH-1:0]   acc_d, prod_d;
  logic [WIDTH-1:0]     quot_d, rem_d;

  always_comb begin
    is_op  = (Signal == F_MULT) || (Signal == F_MULTU) || (Signal == F_DIV) || (Signal == F_DIVU);
    sgn_op = (Signal == F_MULT) || (Signal == F_DIV);
    a_mag  = (sgn_op && dataA[WIDTH-1]) ? -dataA : dataA;
    b_mag  = (sgn_op && dataB[WIDTH-1]) ? -dataB : dataB;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, addend_q} : '0);
    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left.
    div_shift = {acc_q, 1'b0};
    div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, addend_q};

    if (is_div_q)
      acc_d = div_trial[WIDTH] ? div_shift[2*WIDTH-1:0]
                               : {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
    else
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};

    prod_d = neg_q  ? -acc_q : acc_q;
    quot_d = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_d  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      addend_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && is_op) begin
            state_q  <= CALC;
            busy_q   <= 1'b1;
            dz_q     <= 1'b0;
            is_div_q <= Signal[1];
            neg_q    <= sgn_op && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
            rneg_q   <= sgn_op && dataA[WIDTH-1];
            bz_q     <= (dataB == '0);
            cnt_q    <= CW'(WIDTH - 1);
            addend_q <= Signal[1] ? b_mag : a_mag;
            acc_q    <= {{WIDTH{1'b0}}, (Signal[1] ? a_mag : b_mag)};
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0)
            state_q <= FIX;
        end
        FIX: begin
          if (is_div_q) begin
            // Zero divisor: remainder path already yields the dividend; quotient forced to all ones.
            hi_q <= rem_d;
            lo_q <= bz_q ? '1 : quot_d;
            dz_q <= bz_q;
          end else begin
            hi_q <= prod_d[2*WIDTH-1:WIDTH];
            lo_q <= prod_d[WIDTH-1:0];
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    Output = '0;
    case (Signal)
      F_MFHI:  Output = hi_q;
      F_MFLO:  Output = lo_q;
      default: Output = '0;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;

endmodule
